// File: rtl/regfile_pkg.sv
// Shared constants, dump-state encoding and address helper for the register-file dump engine.
// Pure declarations; no logic, no latency, no flow control.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        DONE
    } dump_state_t;

    // Step to the next register and wrap to 0 after the last one.
    function automatic logic [ADDR_W-1:0] addr_wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(NUM_REGS - 1)) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/regdump_addr_ctr.sv
// Dump address walker: loads the first register and the last register, then steps modulo NUM_REGS.
// Latency: cur updates one cycle after load/inc; at_hi is combinational from cur.
// Backpressure: none of its own; it only steps when the caller pulses inc.
module regdump_addr_ctr
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] lo,
    input  logic [ADDR_W-1:0] hi,
    output logic [ADDR_W-1:0] cur,
    output logic              at_hi
);

    logic [ADDR_W-1:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur  <= '0;
            hi_q <= '0;
        end else if (load) begin
            cur  <= lo;
            hi_q <= hi;
        end else if (inc) begin
            cur  <= addr_wrap_inc(cur);
        end
    end

    assign at_hi = (cur == hi_q);

endmodule

// File: rtl/regfile_dump_engine.sv
// Register-file dump sequencer: walks lo..hi (wrapping) on one read port and streams words out.
// Latency: start to first out_valid is 2 cycles; one word every 2 cycles with out_ready held high.
// Backpressure: out_* holds while out_valid && !out_ready. REGDUMP_CHECKSUM_EN adds a trailing XOR beat.
module regfile_dump_engine
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       state, state_nxt;
    logic              ctr_load, ctr_inc, at_hi, hs, kill;
    logic [ADDR_W-1:0] cur;

    regdump_addr_ctr u_ctr (
        .clk   (clk),
        .reset (reset),
        .load  (ctr_load),
        .inc   (ctr_inc),
        .lo    (lo_addr),
        .hi    (hi_addr),
        .cur   (cur),
        .at_hi (at_hi)
    );

    assign hs   = out_valid && out_ready;
    assign kill = abort && (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ctr_load  = 1'b0;
        ctr_inc   = 1'b0;
        case (state)
            IDLE: if (start) begin
                ctr_load  = 1'b1;
                state_nxt = FETCH;
            end
            FETCH: state_nxt = SEND;
            SEND: if (hs) begin
                if (at_hi) begin
`ifdef REGDUMP_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = DONE;
`endif
                end else begin
                    ctr_inc   = 1'b1;
                    state_nxt = FETCH;
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: if (hs) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (kill) begin
            state_nxt = IDLE;
            ctr_inc   = 1'b0;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE) && !abort;
    assign rf_addr = busy ? cur : '0;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else if (kill) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
`ifdef REGDUMP_CHECKSUM_EN
                IDLE: if (start) csum <= '0;
`endif
                // Capture on the FETCH edge so a same-cycle core write is not observed.
                FETCH: begin
                    out_valid <= 1'b1;
                    out_data  <= rf_data;
                    out_addr  <= cur;
`ifdef REGDUMP_CHECKSUM_EN
                    out_last  <= 1'b0;
                    csum      <= csum ^ rf_data;
`else
                    out_last  <= at_hi;
`endif
                end
                SEND: if (hs) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    // cur still equals hi here, so out_addr stays on the last register.
                    if (at_hi) begin
                        out_valid <= 1'b1;
                        out_data  <= csum;
                        out_last  <= 1'b1;
                    end
`endif
                end
                CSUM: if (hs) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: table of dump cases plus hand sequences, scoreboarded beats.
module tb_regfile_dump_engine;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset, start, abort, busy, done, out_valid, out_last;
    logic              out_ready = 1'b1;
    logic [ADDR_W-1:0] lo_addr, hi_addr, rf_addr, out_addr;
    logic [DATA_W-1:0] rf_data, out_data;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rf     [NUM_REGS];
    logic [DATA_W-1:0] shadow [NUM_REGS];

    always #5 clk = ~clk;
    assign rf_data = rf[rf_addr];
    always @(posedge clk) if (we) rf[wa] <= wd;

    regfile_dump_engine dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .lo_addr(lo_addr), .hi_addr(hi_addr), .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS_EXTRA = 1;
`else
    localparam int CS_EXTRA = 0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        int    poke_a;
        int    poke_v;
        int    lo;
        int    hi;
        int    stall_beat;
        int    stall_len;
        int    exp_cycles;
        string name;
    } vec_t;

    beat_t exp_q[$];
    int    checks = 0, errors = 0;
    int    cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0, done_base = 0;
    int    beat_idx = 0, stall_beat = -1, stall_len = 0, stall_cnt = 0;
    logic  prev_last_hs = 1'b0, holding = 1'b0;
    beat_t held;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        beat_t cur_b, b;
        cur_b = {out_addr, out_data, out_last};
        if (reset) begin
            prev_last_hs = 1'b0;
            holding      = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_after_last_beat", {63'd0, prev_last_hs}, 64'd1);
            end
            prev_last_hs = 1'b0;
            if (out_valid) begin
                if (holding) check("stall_stable", cur_b, held);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_beat: got %0h expected no beat", cur_b);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat", cur_b, b);
                    end
                    beat_idx++;
                    prev_last_hs = out_last;
                    holding      = 1'b0;
                end else begin
                    held    = cur_b;
                    holding = 1'b1;
                    stall_cnt++;
                end
            end else begin
                holding = 1'b0;
            end
        end
        out_ready = !(beat_idx == stall_beat && stall_cnt < stall_len);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input int a, input int v);
        we = 1'b1; wa = ADDR_W'(a); wd = DATA_W'(v);
        shadow[a] = DATA_W'(v);
        tick();
        we = 1'b0;
    endtask

    task automatic start_dump(input int lo, input int hi);
        int a;
        logic [DATA_W-1:0] x;
        a = lo;
        x = '0;
        forever begin
            x ^= shadow[a];
`ifdef REGDUMP_CHECKSUM_EN
            exp_q.push_back({ADDR_W'(a), shadow[a], 1'b0});
`else
            exp_q.push_back({ADDR_W'(a), shadow[a], a == hi});
`endif
            if (a == hi) break;
            a = (a + 1) % NUM_REGS;
        end
`ifdef REGDUMP_CHECKSUM_EN
        exp_q.push_back({ADDR_W'(hi), x, 1'b1});
`endif
        beat_idx  = 0;
        stall_cnt = 0;
        done_base = done_cnt;
        lo_addr = ADDR_W'(lo); hi_addr = ADDR_W'(hi); start = 1'b1;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic finish_dump(input string name, input int exp_cycles);
        for (int i = 0; i < 300 && busy; i++) tick();
        check({name, "_timeout"}, {63'd0, busy}, 64'd0);
        check({name, "_cycles"}, done_cyc - start_cyc, exp_cycles);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_done_count"}, done_cnt - done_base, 1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 300 && beat_idx < n; i++) tick();
        check("wait_beats_timeout", {63'd0, beat_idx >= n}, 64'd1);
    endtask

    vec_t vecs[4];

    initial begin
        vecs[0] = '{10, 31, 10, 10, -1, 0, 2,  "single"};
        vecs[1] = '{10, 30, 0,  31, -1, 0, 64, "full"};
        vecs[2] = '{0,  0,  30, 1,  -1, 0, 8,  "wrap"};
        vecs[3] = '{0,  0,  0,  5,  2,  5, 17, "stall"};

        reset = 1'b1; start = 1'b0; abort = 1'b0; we = 1'b0; wa = '0; wd = '0;
        lo_addr = '0; hi_addr = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_last",  {63'd0, out_last},  64'd0);
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_done",      {63'd0, done},      64'd0);
        check("rst_rf_addr",   rf_addr,  64'd0);
        check("rst_out_data",  out_data, 64'd0);
        check("rst_out_addr",  out_addr, 64'd0);

        for (int k = 0; k < NUM_REGS; k++) poke(k, k * 3);

        foreach (vecs[i]) begin
            poke(vecs[i].poke_a, vecs[i].poke_v);
            stall_beat = vecs[i].stall_beat;
            stall_len  = vecs[i].stall_len;
            start_dump(vecs[i].lo, vecs[i].hi);
            finish_dump(vecs[i].name, vecs[i].exp_cycles + CS_EXTRA);
        end
        stall_beat = -1;
        stall_len  = 0;

        // Core writes reg5 in the very cycle FETCH reads it: the old value is captured.
        start_dump(5, 5);
        we = 1'b1; wa = 5'd5; wd = 32'd255;
        tick();
        we = 1'b0;
        shadow[5] = 32'd255;
        finish_dump("coh_old", 2 + CS_EXTRA);

        start_dump(5, 5);
        check("lat_fetch_no_valid", {63'd0, out_valid}, 64'd0);
        tick();
        check("lat_send_valid", {63'd0, out_valid}, 64'd1);
        finish_dump("coh_new", 2 + CS_EXTRA);

        // start and abort together in IDLE: start wins.
        abort = 1'b1;
        start_dump(3, 3);
        abort = 1'b0;
        finish_dump("start_abort", 2 + CS_EXTRA);

        // Abort mid-dump, with an ignored start while busy.
        start_dump(0, 31);
        wait_beats(3);
        lo_addr = 5'd7; hi_addr = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_last",  {63'd0, out_last},  64'd0);
        check("abort_busy",  {63'd0, busy},      64'd0);
        exp_q.delete();
        repeat (4) tick();
        check("abort_no_done", done_cnt - done_base, 0);

        // Reset mid-dump.
        start_dump(0, 31);
        wait_beats(2);
        reset = 1'b1;
        tick();
        check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_busy",  {63'd0, busy},      64'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        check("rst_mid_no_done", done_cnt - done_base, 0);

        // Two-register dump; the checksum build appends a 0xFF beat.
        poke(1, 'h0F);
        poke(2, 'hF0);
        start_dump(1, 2);
        finish_dump("csum", 4 + CS_EXTRA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
